uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter (the uart_top TX path) between NUM_REQ byte producers.
- Accepts one byte at a time from the winning requester and issues a single-cycle wr_en with data to the UART.
- Tracks the UART busy flag through the whole frame before it grants again.
- Sits between the on-chip byte sources and the uart_top wr_en/data_in/busy interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the UART data_in width.
- BUSY_TIMEOUT, 16, cycles to wait for uart_busy to rise after wr_en before the transfer is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high until the matching gnt.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-cycle acceptance pulse, one-hot.
- uart_wr_en  output  1  write strobe to the UART.
- uart_data  output  DATA_W  byte to the UART data_in.
- uart_busy  input  1  UART transmitter busy.
- active_id  output  $clog2(NUM_REQ)  index of the requester currently being served.
- arb_busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse when a transfer is abandoned.

Behaviour:
- Reset (rst low, asynchronous): all outputs return to 0 and state goes to IDLE.
  - Round-robin pointer resets to 0, so requester 0 has highest priority.
  - Timeout counter clears.
  - Reset mid-transfer drops uart_wr_en immediately. The byte in flight is not re-granted.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- IDLE:
  - Arbitration is evaluated only here, and only when req != 0 and uart_busy == 0.
  - Winner = first asserted req at or after the pointer, scanning upward and wrapping from NUM_REQ-1 to 0.
  - On the arbitration edge: latch the winner's byte into uart_data, set active_id, go to ISSUE.
  - If uart_busy is high (external activity), no grant is made.
- ISSUE (exactly 1 cycle):
  - uart_wr_en = 1 and gnt[active_id] = 1 in the same cycle.
  - Pointer <= active_id + 1, wrapping to 0.
  - Next state is WAIT_BUSY; the timeout counter clears.
- WAIT_BUSY:
  - uart_busy == 1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT-1: err_timeout pulses for 1 cycle, state goes to IDLE.
- WAIT_DONE: uart_busy == 0 -> IDLE. There is no timeout in this state.
- Latency: arbitration edge to wr_en/gnt = 1 cycle.
  - With the UART raising busy one cycle after wr_en, the earliest next grant comes 2 cycles after busy falls (IDLE arbitrates, then ISSUE).
- uart_data holds its value from ISSUE until the next arbitration. It changes only on arbitration or reset.
- Requester rules:
  - A requester that deasserts req before its gnt simply loses the slot. This is legal.
  - The data is sampled only on the arbitration edge, so changing req_data after arbitration has no effect.
  - A requester that keeps req high after gnt is treated as a new request and competes at the lowest priority.
- Simultaneous requests: strict round robin, so no requester is granted twice while another is waiting.
- Invariants: gnt is never more than one-hot. uart_wr_en == |gnt at all times.

Test Plan:
- Single byte: req[1]=1 with byte 0x12 while the UART is idle. Expect:
  - gnt[1] and wr_en 1 cycle after arbitration, uart_data=0x12, active_id=1.
  - The UART loopback dout reads 0x12.
- Fairness: req=4'b1111 held high, bytes 0x50/0x51/0x52/0x53. Expect:
  - Grant order 0,1,2,3,0.
  - Exactly one wr_en per UART frame; no new wr_en while busy is high.
- Wrap-around: after a grant to 3, assert req=4'b1001. Expect a grant to 0 next, then 3.
- Timeout: tie uart_busy to 0 and assert req[2] with byte 0x77. Expect:
  - wr_en, then err_timeout pulsing exactly BUSY_TIMEOUT cycles after ISSUE.
  - Return to IDLE, then a fresh grant.
- External busy: hold uart_busy=1 in IDLE with req[0]=1. Expect no gnt; the grant follows 1 cycle after busy falls.
- Reset mid-frame: assert rst low during WAIT_DONE. Expect:
  - All outputs 0 immediately, pointer back at 0.
  - After rst releases, req=4'b1010 grants 1 first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the byte producers, the round-robin arbiter and the UART TX port.
// master is the arbiter; slave is the combined producer/UART side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      uart_wr_en;
    logic [DATA_W-1:0]         uart_data;
    logic                      uart_busy;
    logic [ID_W-1:0]           active_id;
    logic                      arb_busy;
    logic                      err_timeout;

    modport master (
        input  req, req_data, uart_busy,
        output gnt, uart_wr_en, uart_data, active_id, arb_busy, err_timeout
    );

    modport slave (
        output req, req_data, uart_busy,
        input  gnt, uart_wr_en, uart_data, active_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// One byte per grant; the UART busy flag is tracked through the whole frame before re-arbitrating.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             win_valid;
    logic [ID_W-1:0]  win_id;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        // Scan from the far end so the requester closest to ptr is written last and wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (bus.req[rr_index(ptr, off)]) begin
                win_valid = 1'b1;
                win_id    = rr_index(ptr, off);
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.gnt         <= '0;
            bus.uart_wr_en  <= 1'b0;
            bus.uart_data   <= '0;
            bus.active_id   <= '0;
            bus.arb_busy    <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.gnt         <= '0;
            bus.uart_wr_en  <= 1'b0;
            bus.err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_valid && !bus.uart_busy) begin
                        state          <= ISSUE;
                        bus.active_id  <= win_id;
                        bus.uart_data  <= bus.req_data[int'(win_id)*DATA_W +: DATA_W];
                        bus.gnt        <= NUM_REQ'(1) << win_id;
                        bus.uart_wr_en <= 1'b1;
                        bus.arb_busy   <= 1'b1;
                    end
                end

                ISSUE: begin
                    state <= WAIT_BUSY;
                    cnt   <= '0;
                    ptr   <= (bus.active_id == ID_LAST) ? '0 : bus.active_id + 1'b1;
                end

                WAIT_BUSY: begin
                    if (bus.uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt + 1'b1 == CNT_LAST) begin
                        // UART never acknowledged the strobe: drop the byte and free the port.
                        state           <= IDLE;
                        cnt             <= '0;
                        bus.arb_busy    <= 1'b0;
                        bus.err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (!bus.uart_busy) begin
                        state        <= IDLE;
                        bus.arb_busy <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.arb_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transaction-level model checked every cycle,
// a small UART stub that holds busy for a frame, and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TO    = 16;
    localparam int FRAME = 10;
    localparam int IDW   = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer lives from its grant until busy has risen and fallen again, or until
    // TO cycles pass after the grant without busy.
    int           m_ptr = 0;
    int           m_cur = 0;
    int           m_age = 0;
    bit           m_xfer = 1'b0;
    bit           m_seen_busy = 1'b0;
    logic [N-1:0] e_gnt = '0;
    logic         e_wr = 1'b0;
    logic         e_abusy = 1'b0;
    logic         e_err = 1'b0;
    logic [DW-1:0]  e_data = '0;
    logic [IDW-1:0] e_id = '0;

    function automatic int pick(input logic [N-1:0] r, input int base);
        for (int k = 0; k < N; k++)
            if (r[(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr = 0; m_cur = 0; m_age = 0; m_xfer = 1'b0; m_seen_busy = 1'b0;
            e_gnt = '0; e_wr = 1'b0; e_abusy = 1'b0; e_err = 1'b0; e_data = '0; e_id = '0;
        end else begin
            e_gnt = '0;
            e_wr  = 1'b0;
            e_err = 1'b0;
            if (!m_xfer) begin
                if (bus.req != '0 && !bus.uart_busy) begin
                    m_cur       = pick(bus.req, m_ptr);
                    m_xfer      = 1'b1;
                    m_age       = 0;
                    m_seen_busy = 1'b0;
                    e_gnt       = N'(1) << m_cur;
                    e_wr        = 1'b1;
                    e_data      = bus.req_data[m_cur*DW +: DW];
                    e_id        = IDW'(m_cur);
                    e_abusy     = 1'b1;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_ptr = (m_cur + 1) % N;
                end else if (!m_seen_busy) begin
                    if (bus.uart_busy) m_seen_busy = 1'b1;
                    else if (m_age == TO) begin
                        e_err = 1'b1; m_xfer = 1'b0; e_abusy = 1'b0;
                    end
                end else if (!bus.uart_busy) begin
                    m_xfer = 1'b0; e_abusy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("gnt",         32'(bus.gnt),         32'(e_gnt));
        check("uart_wr_en",  32'(bus.uart_wr_en),  32'(e_wr));
        check("uart_data",   32'(bus.uart_data),   32'(e_data));
        check("active_id",   32'(bus.active_id),   32'(e_id));
        check("arb_busy",    32'(bus.arb_busy),    32'(e_abusy));
        check("err_timeout", 32'(bus.err_timeout), 32'(e_err));
        check("gnt_onehot",  32'($countones(bus.gnt) <= 1), 32'(1));
        check("wr_en_is_or_gnt", 32'(bus.uart_wr_en), 32'(|bus.gnt));
        if (bus.uart_wr_en) check("wr_en_while_busy", 32'(bus.uart_busy), 32'(0));
    end

    // Stimulus-side state: UART stub and requester hold mask.
    logic [N-1:0]  hold = '0;
    bit            force_busy = 1'b0;
    bit            kill_busy = 1'b0;
    int            frame_left = 0;
    logic [DW-1:0] loop_dout = '0;
    int            exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic update_busy();
        bus.uart_busy = force_busy || (!kill_busy && frame_left > 0);
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        bus.req_data[i*DW +: DW] = b;
    endtask

    function automatic int onehot_id(input logic [N-1:0] g);
        for (int k = 0; k < N; k++)
            if (g[k]) return k;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
        if (!rst) frame_left = 0;
        else if (bus.uart_wr_en) begin
            frame_left = FRAME;
            loop_dout  = bus.uart_data;
        end else if (frame_left > 0) frame_left--;
        for (int i = 0; i < N; i++)
            if (bus.gnt[i] && !hold[i]) bus.req[i] = 1'b0;
        update_busy();
    endtask

    task automatic wait_gnt(input string name, output int id, output int cycles);
        id = -1;
        cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.gnt != '0) begin
                cycles = n;
                id = onehot_id(bus.gnt);
                break;
            end
        end
        check(name, 32'(id >= 0), 32'(1));
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!bus.arb_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'(1));
    endtask

    initial begin
        int id;
        int cyc;
        int n_err;
        bit saw;

        rst = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.uart_busy = 1'b0;
        repeat (2) tick();
        check("rst_gnt",       32'(bus.gnt),         32'(0));
        check("rst_wr_en",     32'(bus.uart_wr_en),  32'(0));
        check("rst_data",      32'(bus.uart_data),   32'(0));
        check("rst_active_id", 32'(bus.active_id),   32'(0));
        check("rst_arb_busy",  32'(bus.arb_busy),    32'(0));
        check("rst_err",       32'(bus.err_timeout), 32'(0));
        rst = 1'b1;
        tick();

        // Fairness: all four held high, strict rotation starting at 0.
        for (int i = 0; i < N; i++) set_byte(i, 8'(8'h50 + i));
        hold = '1;
        bus.req = '1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt("fair_gnt_seen", id, cyc);
            check("fair_order", 32'(id), 32'(exp_order[g]));
            check("fair_data", 32'(bus.uart_data), 32'(8'h50 + exp_order[g]));
        end
        hold = '0;
        bus.req = '0;
        wait_idle("fair_idle");

        // Single byte on requester 1.
        set_byte(1, 8'h12);
        bus.req = 4'b0010;
        wait_gnt("single_gnt_seen", id, cyc);
        check("single_latency", 32'(cyc), 32'(1));
        check("single_gnt", 32'(bus.gnt), 32'(4'b0010));
        check("single_wr_en", 32'(bus.uart_wr_en), 32'(1));
        check("single_data", 32'(bus.uart_data), 32'(8'h12));
        check("single_id", 32'(bus.active_id), 32'(1));
        check("single_loopback", 32'(loop_dout), 32'(8'h12));
        wait_idle("single_idle");

        // Timeout: UART never raises busy.
        kill_busy = 1'b1;
        update_busy();
        set_byte(2, 8'h77);
        bus.req[2] = 1'b1;
        wait_gnt("to_gnt_seen", id, cyc);
        check("to_id", 32'(id), 32'(2));
        check("to_data", 32'(bus.uart_data), 32'(8'h77));
        n_err = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.err_timeout) begin
                n_err = n;
                break;
            end
        end
        check("to_err_delay", 32'(n_err), 32'(TO));
        check("to_back_idle", 32'(bus.arb_busy), 32'(0));
        kill_busy = 1'b0;
        update_busy();
        set_byte(3, 8'h33);
        bus.req[3] = 1'b1;
        wait_gnt("fresh_gnt_seen", id, cyc);
        check("fresh_id", 32'(id), 32'(3));
        wait_idle("fresh_idle");

        // Wrap-around after a grant to 3.
        set_byte(0, 8'hA0);
        set_byte(3, 8'hA3);
        bus.req = 4'b1001;
        wait_gnt("wrap_gnt0_seen", id, cyc);
        check("wrap_first", 32'(id), 32'(0));
        check("wrap_first_data", 32'(bus.uart_data), 32'(8'hA0));
        wait_gnt("wrap_gnt1_seen", id, cyc);
        check("wrap_second", 32'(id), 32'(3));
        check("wrap_second_data", 32'(bus.uart_data), 32'(8'hA3));
        wait_idle("wrap_idle");

        // External busy in IDLE blocks arbitration.
        force_busy = 1'b1;
        update_busy();
        set_byte(0, 8'h5A);
        bus.req[0] = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            tick();
            if (bus.gnt != '0) saw = 1'b1;
        end
        check("ext_no_gnt", 32'(saw), 32'(0));
        force_busy = 1'b0;
        update_busy();
        wait_gnt("ext_gnt_seen", id, cyc);
        check("ext_latency", 32'(cyc), 32'(1));
        check("ext_id", 32'(id), 32'(0));
        check("ext_data", 32'(bus.uart_data), 32'(8'h5A));
        wait_idle("ext_idle");

        // Reset during WAIT_DONE with the pointer at 3.
        set_byte(2, 8'h22);
        bus.req[2] = 1'b1;
        wait_gnt("rmf_gnt_seen", id, cyc);
        check("rmf_id", 32'(id), 32'(2));
        repeat (3) tick();
        check("rmf_busy_before", 32'(bus.arb_busy), 32'(1));
        rst = 1'b0;
        #1;
        check("rmf_gnt",       32'(bus.gnt),         32'(0));
        check("rmf_wr_en",     32'(bus.uart_wr_en),  32'(0));
        check("rmf_data",      32'(bus.uart_data),   32'(0));
        check("rmf_active_id", 32'(bus.active_id),   32'(0));
        check("rmf_arb_busy",  32'(bus.arb_busy),    32'(0));
        check("rmf_err",       32'(bus.err_timeout), 32'(0));
        repeat (2) tick();
        rst = 1'b1;
        set_byte(1, 8'hB1);
        set_byte(3, 8'hB3);
        bus.req = 4'b1010;
        wait_gnt("post_rst_gnt0_seen", id, cyc);
        check("post_rst_first", 32'(id), 32'(1));
        check("post_rst_first_data", 32'(bus.uart_data), 32'(8'hB1));
        wait_gnt("post_rst_gnt1_seen", id, cyc);
        check("post_rst_second", 32'(id), 32'(3));
        check("post_rst_second_data", 32'(bus.uart_data), 32'(8'hB3));
        wait_idle("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
